// File: rtl/alt_dprio_arb_pkg.sv
// Shared types and helpers for the DPRIO round-robin arbiter.
package alt_dprio_arb_pkg;

    localparam int DPRIO_AW = 16;
    localparam int DPRIO_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_e;

    // Next round-robin pointer: one past the winner, wrapping at n.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/alt_dprio_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module alt_dprio_rr_pick
    import alt_dprio_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic               any,
    output logic [PW-1:0]      winner,
    output logic [NUM_REQ-1:0] grant
);

    // Index of the k-th candidate counted from ptr, modulo NUM_REQ.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return PW'(s);
    endfunction

    // Scan from the farthest candidate down so the nearest set bit wins last.
    always_comb begin
        any    = |req;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(ptr, k)]) begin
                winner = wrap_idx(ptr, k);
            end
        end
        grant = any ? (NUM_REQ'(1) << winner) : '0;
    end

endmodule

// File: rtl/alt_dprio_arbiter.sv
// Round-robin arbiter sharing one DPRIO port between NUM_REQ requesters.
module alt_dprio_arbiter
    import alt_dprio_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [DPRIO_AW*NUM_REQ-1:0] req_addr,
    input  logic [DPRIO_DW*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DPRIO_DW-1:0]         rsp_rdata,
    output logic                        rsp_error,
    output logic [DPRIO_AW-1:0]         dprio_addr,
    output logic [DPRIO_DW-1:0]         dprio_dataout,
    output logic                        dprio_rden,
    output logic                        dprio_wren,
    input  logic                        dprio_busy,
    input  logic [DPRIO_DW-1:0]         dprio_datain,
    output logic                        busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e           state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        win_q, win_d;
    logic                 wr_q, wr_d;
    logic [DPRIO_AW-1:0]  addr_q, addr_d;
    logic [DPRIO_DW-1:0]  wdata_q, wdata_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        cnt_inc;
    logic                 first_q, first_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DPRIO_DW-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_error_q, rsp_error_d;
    logic                 rden_q, rden_d;
    logic                 wren_q, wren_d;
    logic                 busy_q, busy_d;

    logic                 pick_any;
    logic [PW-1:0]        pick_winner;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [DPRIO_AW-1:0]  addr_arr  [NUM_REQ];
    logic [DPRIO_DW-1:0]  wdata_arr [NUM_REQ];

    alt_dprio_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req    (req_valid),
        .ptr    (ptr_q),
        .any    (pick_any),
        .winner (pick_winner),
        .grant  (pick_grant)
    );

    // Split the flat request buses into per-requester words.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i]  = req_addr[DPRIO_AW*i +: DPRIO_AW];
            wdata_arr[i] = req_wdata[DPRIO_DW*i +: DPRIO_DW];
        end
    end

    // FSM next-state: accept, strobe, wait for busy to fall or time out, respond.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        rden_d      = 1'b0;
        wren_d      = 1'b0;
        cnt_inc     = (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    win_d       = pick_winner;
                    wr_d        = req_write[pick_winner];
                    addr_d      = addr_arr[pick_winner];
                    wdata_d     = wdata_arr[pick_winner];
                    req_ready_d = pick_grant;
                    ptr_d       = PW'(rr_next(int'(pick_winner), NUM_REQ));
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!dprio_busy) begin
                    rden_d  = ~wr_q;
                    wren_d  = wr_q;
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                first_d = 1'b0;
                if (dprio_busy) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
                        rsp_valid_d = NUM_REQ'(1) << win_q;
                        rsp_rdata_d = '0;
                        rsp_error_d = 1'b1;
                        state_d     = ST_RESPOND;
                    end
                end else if (!first_q) begin
                    rsp_valid_d = NUM_REQ'(1) << win_q;
                    rsp_rdata_d = wr_q ? '0 : dprio_datain;
                    rsp_error_d = 1'b0;
                    state_d     = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                addr_d  = '0;
                wdata_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            rden_q      <= rden_d;
            wren_q      <= wren_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_error     = rsp_error_q;
    assign dprio_addr    = addr_q;
    assign dprio_dataout = wdata_q;
    assign dprio_rden    = rden_q;
    assign dprio_wren    = wren_q;
    assign busy          = busy_q;

endmodule
